fft64_frame_sched: RTL and testbench
====================================

// Module: fft64_frame_sched
// PURPOSE
//  Streaming front/back-end controller for the 64-point parallel pipelined FFT core.
//  Collects one complex sample per handshake into a 64-entry frame buffer and launches the core with a 1-cycle start.
//  Supervises the core's fixed latency and serialises the natural-order result back out over a valid/ready stream.
//  At most one frame is in flight in the core; the next frame fills while the current one runs.
// PARAMETERS
//  DATA_WIDTH  16   bits per real/imag component, Q1.15 signed
//  N_POINTS    64   frame length; must equal the core's point count (power of 2)
//  FFT_LAT     8    core latency: start asserted in cycle 0 -> done asserted in cycle FFT_LAT
//  TIMEOUT     16   WAIT cycles (counted from start) after which a missing done is a protocol error; > FFT_LAT
// PORTS
//  clk           in   1             rising-edge clock
//  rst           in   1             asynchronous, active-high reset
//  in_valid      in   1             input sample valid
//  in_ready      out  1             controller can accept a sample
//  in_real       in   DATA_WIDTH    input sample, real part
//  in_imag       in   DATA_WIDTH    input sample, imaginary part
//  fft_start     out  1             1-cycle launch pulse to core
//  fft_din_real  out  N*DATA_WIDTH  frame buffer, real; sample k at [k*DW +: DW]
//  fft_din_imag  out  N*DATA_WIDTH  frame buffer, imaginary; same packing
//  fft_dout_real in   N*DATA_WIDTH  core result, real; bin k at [k*DW +: DW]
//  fft_dout_imag in   N*DATA_WIDTH  core result, imaginary; same packing
//  fft_done      in   1             core result valid (1 cycle)
//  out_valid     out  1             output bin valid
//  out_ready     in   1             downstream accepts bin
//  out_real      out  DATA_WIDTH    output bin, real
//  out_imag      out  DATA_WIDTH    output bin, imaginary
//  out_idx       out  log2(N)       bin index of the current output, 0..N-1
//  out_last      out  1             high with bin N-1
//  busy          out  1             exec FSM not IDLE
//  err           out  1             sticky protocol error
//  err_clr       in   1             clears err; a new error in the same cycle wins
//  frame_cnt     out  16            frames fully drained, wraps at 2^16
// BEHAVIOUR
//  Reset: in FILL with wr_idx=0. Exec FSM in IDLE.
//  Reset values: in_ready=1 after reset release; every other output, buffer and counter = 0.
//  Reset mid-operation drops all frames with no start or out_valid glitch; the core shares rst.
//  Input FSM:
//   - FILL: in_ready=1. On in_valid&&in_ready, store the sample at wr_idx and increment wr_idx.
//   - On handshake with wr_idx=N-1, go to FULL and wrap wr_idx to 0.
//   - FULL: in_ready=0; fft_din_* hold stable.
//  Launch: when input FSM is FULL and exec FSM is IDLE, fft_start=1 for exactly one cycle.
//   - On the same edge: input FSM -> FILL (in_ready=1 next cycle), exec FSM -> WAIT with lat_cnt=0.
//   - The core samples fft_din_* on the start cycle, so the buffer may be overwritten afterwards.
//  Exec FSM:
//   - IDLE: waits for launch.
//   - WAIT: lat_cnt increments each cycle. On fft_done, capture fft_dout_* into the output register, rd_idx=0, go to DRAIN.
//   - WAIT timeout: lat_cnt==TIMEOUT without done -> set err, go to IDLE, discard the frame.
//   - DRAIN: out_valid=1, out_* = bin rd_idx, out_idx=rd_idx, out_last=(rd_idx==N-1).
//   - DRAIN handshake: out_valid&&out_ready increments rd_idx. On the last-bin handshake: frame_cnt++, go to IDLE.
//   - DRAIN with out_ready low: out_* hold.
//  Back-to-back throughput: a launch can fire in the cycle after the last-bin handshake if the buffer is FULL.
//  Error rules:
//   - fft_done seen outside WAIT is spurious: set err and otherwise ignore it.
//   - Output data is taken only from the captured register, never live core outputs.
//  Arithmetic: no data arithmetic in this block; samples pass bit-exact.
//  Counter widths: wr_idx/rd_idx are log2(N) bits and wrap naturally; lat_cnt is clog2(TIMEOUT+1) bits.
// TESTING
//  T1 reset: rst=1 mid-DRAIN -> out_valid=0, fft_start=0, err=0, frame_cnt=0; in_ready=1 after release.
//  T2 impulse: x[0]=16384, x[1..63]=0 with core model -> single fft_start; done 8 cycles later; 64 bins out, all 256 real (six /2 stages), imag 0, out_last on idx 63.
//  T3 backpressure: out_ready toggled 1/0 randomly -> every bin emitted once, in order, stable while stalled.
//  T4 overlap: 3 frames at full in_valid rate with out_ready=1 -> frame 2 fills during frame 1 WAIT/DRAIN; starts spaced >= 8+64 cycles; frame_cnt=3.
//  T5 timeout: core model suppresses done -> err=1 at lat_cnt=16; FSM IDLE; next frame still processed; err_clr -> err=0.
//  T6 spurious: fft_done pulsed while IDLE -> err=1, no out_valid, frame_cnt unchanged.

Source files
------------

// File: rtl/fft64_frame_sched_if.sv
// fft64_frame_sched_if: sample stream, result stream, core hookup and status of the FFT frame scheduler.
interface fft64_frame_sched_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS = 64
);
  logic in_valid, in_ready;
  logic [DATA_WIDTH-1:0] in_real, in_imag;
  logic fft_start, fft_done;
  logic [N_POINTS*DATA_WIDTH-1:0] fft_din_real, fft_din_imag, fft_dout_real, fft_dout_imag;
  logic out_valid, out_ready, out_last;
  logic [DATA_WIDTH-1:0] out_real, out_imag;
  logic [$clog2(N_POINTS)-1:0] out_idx;
  logic busy, err, err_clr;
  logic [15:0] frame_cnt;
  modport slave (
    input in_valid, in_real, in_imag, fft_dout_real, fft_dout_imag, fft_done, out_ready, err_clr,
    output in_ready, fft_start, fft_din_real, fft_din_imag, out_valid, out_real, out_imag, out_idx,
    output out_last, busy, err, frame_cnt
  );
  modport master (
    output in_valid, in_real, in_imag, fft_dout_real, fft_dout_imag, fft_done, out_ready, err_clr,
    input in_ready, fft_start, fft_din_real, fft_din_imag, out_valid, out_real, out_imag, out_idx,
    input out_last, busy, err, frame_cnt
  );
endinterface

// File: rtl/fft64_frame_sched.sv
// fft64_frame_sched: fills a frame buffer, launches the FFT core, supervises its latency
// and serialises the captured result one bin per handshake.
module fft64_frame_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int N_POINTS = 64,
  parameter int FFT_LAT = 8,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst,
  fft64_frame_sched_if.slave bus
);
  localparam int IW = $clog2(N_POINTS);
  localparam int LW = $clog2(TIMEOUT + 1);
  localparam int BW = N_POINTS * DATA_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N_POINTS - 1);
  localparam logic [LW-1:0] LIMIT = LW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} exec_t;
  exec_t state;
  logic full, launch, in_hs, err_q;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [LW-1:0] lat_cnt;
  logic [BW-1:0] buf_real, buf_imag, cap_real, cap_imag;
  logic [15:0] frames;
  if (TIMEOUT <= FFT_LAT) begin : g_bad_timeout
    $error("TIMEOUT must exceed FFT_LAT");
  end
  assign launch = full && state == IDLE;
  assign in_hs = bus.in_valid && !full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      wr_idx <= '0;
      buf_real <= '0;
      buf_imag <= '0;
    end else if (in_hs) begin
      buf_real[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.in_real;
      buf_imag[int'(wr_idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.in_imag;
      wr_idx <= wr_idx + 1'b1;
      full <= wr_idx == LAST;
    end else if (launch) begin
      full <= 1'b0;
    end
  // a done outside WAIT or a WAIT that runs out both latch err; a fresh error beats err_clr
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      rd_idx <= '0;
      cap_real <= '0;
      cap_imag <= '0;
      frames <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= (bus.fft_done && state != WAIT) || (state == WAIT && !bus.fft_done && lat_cnt == LIMIT) ||
               (err_q && !bus.err_clr);
      case (state)
        IDLE: if (launch) begin
          state <= WAIT;
          lat_cnt <= '0;
        end
        WAIT: if (bus.fft_done) begin
          cap_real <= bus.fft_dout_real;
          cap_imag <= bus.fft_dout_imag;
          rd_idx <= '0;
          state <= DRAIN;
        end else if (lat_cnt == LIMIT) begin
          state <= IDLE;
        end else begin
          lat_cnt <= lat_cnt + 1'b1;
        end
        DRAIN: if (bus.out_ready) begin
          rd_idx <= rd_idx + 1'b1;
          if (rd_idx == LAST) begin
            frames <= frames + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  assign bus.in_ready = !full;
  assign bus.fft_start = launch;
  assign bus.fft_din_real = buf_real;
  assign bus.fft_din_imag = buf_imag;
  assign bus.out_valid = state == DRAIN;
  assign bus.out_real = cap_real[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.out_imag = cap_imag[int'(rd_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign bus.out_idx = rd_idx;
  assign bus.out_last = state == DRAIN && rd_idx == LAST;
  assign bus.busy = state != IDLE;
  assign bus.err = err_q;
  assign bus.frame_cnt = frames;
endmodule

// File: tb/tb_fft64_frame_sched.sv
// tb_fft64_frame_sched: directed frame vectors against a behavioural 64-point DFT core model
// (1/64 scaled, fixed 8-cycle latency) with a bin scoreboard.
module tb_fft64_frame_sched;
  localparam int DW = 16, N = 64, BW = DW * N, LAT = 8;
  localparam real PI = 3.14159265358979323846;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  fft64_frame_sched_if #(.DATA_WIDTH(DW), .N_POINTS(N)) bus ();
  fft64_frame_sched #(.DATA_WIDTH(DW), .N_POINTS(N), .FFT_LAT(LAT), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  int checks = 0, errors = 0, fc_exp = 0, rd_ptr = 0;
  logic core_done = 1'b0, spur_done = 1'b0, suppress = 1'b0;
  int core_cnt = 0;
  logic [BW-1:0] res_r = '0, res_i = '0;
  logic [31:0] exp_q[$];
  int cyc = 0, start_cyc = 0, starts = 0;
  int gaps[$];
  assign bus.fft_done = core_done | spur_done;

  function automatic logic [BW-1:0] dft(input logic [BW-1:0] xr, input logic [BW-1:0] xi, input bit want_im);
    logic [BW-1:0] y;
    real sr, si, a, vr, vi;
    y = '0;
    for (int k = 0; k < N; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        a = 2.0 * PI * n * k / N;
        vr = $itor($signed(xr[n*DW +: DW]));
        vi = $itor($signed(xi[n*DW +: DW]));
        sr += vr * $cos(a) + vi * $sin(a);
        si += vi * $cos(a) - vr * $sin(a);
      end
      sr = (want_im ? si : sr) / N;
      y[k*DW +: DW] = DW'($rtoi(sr < 0.0 ? sr - 0.5 : sr + 0.5));
    end
    return y;
  endfunction

  // core model: samples the buffer on start, done in cycle LAT, scrambles its outputs afterwards
  always @(posedge clk or posedge rst)
    if (rst) begin
      core_cnt <= 0;
      core_done <= 1'b0;
      bus.fft_dout_real <= '0;
      bus.fft_dout_imag <= '0;
    end else begin
      core_done <= 1'b0;
      if (core_done) begin
        bus.fft_dout_real <= ~bus.fft_dout_real;
        bus.fft_dout_imag <= ~bus.fft_dout_imag;
      end
      if (bus.fft_start) begin
        res_r <= dft(bus.fft_din_real, bus.fft_din_imag, 1'b0);
        res_i <= dft(bus.fft_din_real, bus.fft_din_imag, 1'b1);
        core_cnt <= LAT - 1;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1 && !suppress) begin
          core_done <= 1'b1;
          bus.fft_dout_real <= res_r;
          bus.fft_dout_imag <= res_i;
          for (int k = 0; k < N; k++) exp_q.push_back({res_r[k*DW +: DW], res_i[k*DW +: DW]});
        end
      end
    end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fft_start) begin
      starts <= starts + 1;
      start_cyc <= cyc;
      gaps.push_back(cyc - start_cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input int kind, input logic [15:0] ar, input logic [15:0] ai);
    int w;
    for (int n = 0; n < N; n++) begin
      w = 0;
      bus.in_valid = 1'b1;
      bus.in_real = kind == 2 ? 16'($urandom) : (kind == 1 || n == 0) ? ar : 16'd0;
      bus.in_imag = kind == 2 ? 16'($urandom) : (kind == 1 || n == 0) ? ai : 16'd0;
      while (!bus.in_ready) begin
        @(negedge clk);
        if (++w > 500) begin
          $display("FAIL in_ready_timeout: got 0 expected 1");
          $fatal(1, "input stalled");
        end
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input int nbins, input bit bp, input bit use_const, input bit chk_lat,
                      input logic [15:0] e0r, input logic [15:0] e0i, input logic [15:0] ekr, input logic [15:0] eki);
    int got = 0, idle = 0;
    bit stalled = 1'b0, first = 1'b1;
    logic [31:0] held_d = '0, e;
    logic [5:0] held_i = '0;
    while (got < nbins) begin
      @(negedge clk);
      if (stalled && bus.out_valid) begin
        chk("stall_data_hold", {bus.out_real, bus.out_imag}, held_d);
        chk("stall_idx_hold", 32'(bus.out_idx), 32'(held_i));
      end
      stalled = 1'b0;
      if (bus.out_valid && first) begin
        first = 1'b0;
        if (chk_lat) chk("first_out_latency", 32'(cyc - start_cyc), 32'd9);
      end
      bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        e = rd_ptr < exp_q.size() ? exp_q[rd_ptr] : 32'hDEADBEEF;
        rd_ptr++;
        chk("out_idx", 32'(bus.out_idx), 32'(got % N));
        chk("out_last", 32'(bus.out_last), 32'((got % N) == N - 1));
        chk("out_vs_core", {bus.out_real, bus.out_imag}, e);
        if (use_const) chk("out_vs_table", {bus.out_real, bus.out_imag}, (got % N) == 0 ? {e0r, e0i} : {ekr, eki});
        got++;
        idle = 0;
      end else begin
        if (bus.out_valid) begin
          stalled = 1'b1;
          held_d = {bus.out_real, bus.out_imag};
          held_i = bus.out_idx;
        end
        if (++idle > 400) begin
          $display("FAIL out_valid_timeout: got %0d bins expected %0d", got, nbins);
          $fatal(1, "output stalled");
        end
      end
    end
    bus.out_ready = 1'b1;
  endtask

  typedef struct {
    int kind;
    logic [15:0] ar, ai;
    bit bp;
    logic [15:0] e0r, e0i, ekr, eki;
  } vec_t;
  vec_t vecs[6];

  initial begin
    int s0, base, w;
    bit seen;
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, base, w;
    bit seen;
    vecs[0] = '{0, 16'd16384, 16'd0, 1'b0, 16'd256, 16'd0, 16'd256, 16'd0};
    vecs[1] = '{0, 16'hE000, 16'd0, 1'b1, 16'hFF80, 16'd0, 16'hFF80, 16'd0};
    vecs[2] = '{0, 16'd0, 16'd6400, 1'b0, 16'd0, 16'd100, 16'd0, 16'd100};
    vecs[3] = '{0, 16'd3200, 16'hF9C0, 1'b1, 16'd50, 16'hFFE7, 16'd50, 16'hFFE7};
    vecs[4] = '{1, 16'd1000, 16'hFE0C, 1'b0, 16'd1000, 16'hFE0C, 16'd0, 16'd0};
    vecs[5] = '{1, 16'h8000, 16'd0, 1'b1, 16'h8000, 16'd0, 16'd0, 16'd0};
    bus.in_valid = 1'b0;
    bus.in_real = '0;
    bus.in_imag = '0;
    bus.out_ready = 1'b1;
    bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_fft_start", 32'(bus.fft_start), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("rst_out_idx_last", 32'({bus.out_idx, bus.out_last}), 32'd0);
    for (int v = 0; v < 6; v++) begin
      s0 = starts;
      send_frame(vecs[v].kind, vecs[v].ar, vecs[v].ai);
      recv(N, vecs[v].bp, 1'b1, 1'b1, vecs[v].e0r, vecs[v].e0i, vecs[v].ekr, vecs[v].eki);
      @(negedge clk);
      fc_exp++;
      chk("frame_starts", 32'(starts - s0), 32'd1);
      chk("frame_cnt", 32'(bus.frame_cnt), 32'(fc_exp));
      chk("idle_after_frame", 32'({bus.busy, bus.out_valid}), 32'd0);
    end
    s0 = starts;
    base = gaps.size();
    fork
      for (int f = 0; f < 3; f++) send_frame(2, 16'd0, 16'd0);
      recv(3 * N, 1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 16'd0);
    join
    @(negedge clk);
    fc_exp += 3;
    chk("overlap_starts", 32'(starts - s0), 32'd3);
    chk("overlap_frame_cnt", 32'(bus.frame_cnt), 32'(fc_exp));
    chk("overlap_gap_2", 32'(base + 1 < gaps.size() ? gaps[base+1] : 0), 32'd73);
    chk("overlap_gap_3", 32'(base + 2 < gaps.size() ? gaps[base+2] : 0), 32'd73);
    suppress = 1'b1;
    send_frame(0, 16'd16384, 16'd0);
    w = 0;
    seen = 1'b0;
    while (!bus.err && w < 60) begin
      @(negedge clk);
      w++;
      if (bus.out_valid) seen = 1'b1;
    end
    suppress = 1'b0;
    chk("timeout_err", 32'(bus.err), 32'd1);
    chk("timeout_cycle", 32'(cyc - start_cyc), 32'd18);
    chk("timeout_idle", 32'(bus.busy), 32'd0);
    chk("timeout_no_out", 32'(seen), 32'd0);
    send_frame(1, 16'd1000, 16'hFE0C);
    recv(N, 1'b0, 1'b1, 1'b1, 16'd1000, 16'hFE0C, 16'd0, 16'd0);
    @(negedge clk);
    fc_exp++;
    chk("after_timeout_frame_cnt", 32'(bus.frame_cnt), 32'(fc_exp));
    chk("err_sticky", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_cleared", 32'(bus.err), 32'd0);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    chk("spurious_err", 32'(bus.err), 32'd1);
    @(negedge clk);
    chk("spurious_no_out", 32'({bus.out_valid, bus.busy}), 32'd0);
    chk("spurious_frame_cnt", 32'(bus.frame_cnt), 32'(fc_exp));
    spur_done = 1'b1;
    bus.err_clr = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    bus.err_clr = 1'b0;
    chk("new_err_beats_clr", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("err_clr_again", 32'(bus.err), 32'd0);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    bus.out_ready = 1'b0;
    send_frame(0, 16'd16384, 16'd0);
    w = 0;
    while (!bus.out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("drain_reached", 32'(bus.out_valid), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_fft_start", 32'(bus.fft_start), 32'd0);
    chk("midrst_err", 32'(bus.err), 32'd0);
    chk("midrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("midrst_buffer", 32'(bus.fft_din_real == '0), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd_ptr = exp_q.size();
    fc_exp = 0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("postrst_busy", 32'({bus.busy, bus.out_valid}), 32'd0);
    send_frame(0, 16'd16384, 16'd0);
    recv(N, 1'b0, 1'b1, 1'b1, 16'd256, 16'd0, 16'd256, 16'd0);
    @(negedge clk);
    fc_exp++;
    chk("postrst_frame_cnt", 32'(bus.frame_cnt), 32'(fc_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
